// File: rtl/load_store_unit.sv
// Load/store unit between the datapath and a word-addressed, async-read data memory.
// Define LSU_RANGE_CHECK_EN to reject word indices >= DEPTH; otherwise indices wrap modulo DEPTH.
module load_store_unit #(
  parameter int XW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [XW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_err,
  output logic [XW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IW = XW - 2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_RESP, S_ERR} state_e;

  // Replace the addressed byte/half lane of old_w with the low bits of new_d.
  function automatic logic [31:0] merge_lane(input logic [31:0] old_w, input logic [31:0] new_d,
                                             input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] w;
    w = old_w;
    case (size)
      SZ_BYTE: w[{lane, 3'b000} +: 8]       = new_d[7:0];
      SZ_HALF: w[{lane[1], 4'b0000} +: 16] = new_d[15:0];
      default: w = new_d;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] extend_lane(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: r = uns ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_HALF: r = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  logic [IW-1:0] req_idx;
  logic          out_of_range;
  logic          req_bad;

  assign req_idx = req_addr[XW-1:2];

`ifdef LSU_RANGE_CHECK_EN
  assign out_of_range = (req_idx >= IW'(DEPTH));
`else
  // High index bits are dropped so the access wraps modulo DEPTH.
  logic unused_idx_hi;
  assign unused_idx_hi = ^req_idx[IW-1:AW];
  assign out_of_range  = 1'b0;
`endif

  assign req_bad = (req_size == 2'b11) ||
                   ((req_size == SZ_HALF) && req_addr[0]) ||
                   ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00)) ||
                   out_of_range;

  state_e        state_q, state_d;
  logic          is_write_q, is_write_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [1:0]    lane_q, lane_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [XW-1:0] mem_addr_q, mem_addr_d;
  logic          mem_we_q, mem_we_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          resp_valid_q, resp_valid_d;
  logic          resp_err_q, resp_err_d;
  logic [DW-1:0] resp_rdata_q, resp_rdata_d;

  // All outputs are registered and computed for the state being entered, so
  // mem_we/resp_valid are glitch-free and mem_addr/mem_wdata stay put after a write.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d      = state_q;
    is_write_d   = is_write_q;
    size_d       = size_q;
    uns_d        = uns_q;
    lane_d       = lane_q;
    wdata_d      = wdata_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = 1'b0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          is_write_d = req_write;
          size_d     = req_size;
          uns_d      = req_unsigned;
          lane_d     = req_addr[1:0];
          wdata_d    = req_wdata;
          if (req_bad) begin
            state_d      = S_ERR;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            mem_addr_d = XW'(req_idx[AW-1:0]);
            if (req_write && (req_size == SZ_WORD)) begin
              state_d     = S_WR;
              mem_we_d    = 1'b1;
              mem_wdata_d = req_wdata;
            end else begin
              state_d = S_RD;
            end
          end
        end
      end
      S_RD: begin
        if (is_write_q) begin
          state_d     = S_WR;
          mem_we_d    = 1'b1;
          mem_wdata_d = merge_lane(mem_rdata, wdata_q, size_q, lane_q);
        end else begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = extend_lane(mem_rdata, size_q, lane_q, uns_q);
        end
      end
      S_WR: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
      end
      S_RESP, S_ERR: state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      is_write_q   <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      lane_q       <= 2'b00;
      wdata_q      <= '0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      is_write_q   <= is_write_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      lane_q       <= lane_d;
      wdata_q      <= wdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: the driver queues expected responses and
// memory writes, the monitor compares them whenever the DUT presents one.
module tb_load_store_unit;
  localparam int XW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 128;

  logic          clk;
  logic          rst_n;
  logic          req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]    req_size;
  logic [XW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid, resp_err;
  logic [DW-1:0] resp_rdata;
  logic [XW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata, mem_rdata;

  load_store_unit #(.XW(XW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  logic [31:0] mem [DEPTH];
  assign mem_rdata = mem[mem_addr[6:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[6:0]] <= mem_wdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {logic [31:0] rdata; logic err; int lat; int acc;} resp_t;
  typedef struct {logic [31:0] addr; logic [31:0] data; int lat; int acc;} wr_t;
  resp_t resp_q[$];
  wr_t   wr_q[$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  resp_t mon_r;
  wr_t   mon_w;
  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      if (resp_q.size() == 0) check("unexpected_resp", {31'b0, resp_valid}, 32'd0);
      else begin
        mon_r = resp_q.pop_front();
        check("resp_rdata", resp_rdata, mon_r.rdata);
        check("resp_err", {31'b0, resp_err}, {31'b0, mon_r.err});
        check("resp_latency", 32'(cyc - mon_r.acc + 1), 32'(mon_r.lat));
      end
    end
    if (rst_n && mem_we) begin
      if (wr_q.size() == 0) check("unexpected_mem_we", {31'b0, mem_we}, 32'd0);
      else begin
        mon_w = wr_q.pop_front();
        check("mem_addr", mem_addr, mon_w.addr);
        check("mem_wdata", mem_wdata, mon_w.data);
        check("mem_we_latency", 32'(cyc - mon_w.acc + 1), 32'(mon_w.lat));
      end
    end
  end

  task automatic drive(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("req_ready_timeout", {31'b0, req_ready}, 32'd1);
    req_valid    = 1'b1;
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    acc          = cyc + 1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                       input logic exp_we, input logic [31:0] exp_wdata, input int we_lat);
    int acc;
    resp_t r;
    wr_t   w;
    drive(wr, sz, uns, addr, wdata, acc);
    r.rdata = exp_rdata; r.err = exp_err; r.lat = exp_lat; r.acc = acc;
    resp_q.push_back(r);
    if (exp_we) begin
      w.addr = 32'(addr[8:2]); w.data = exp_wdata; w.lat = we_lat; w.acc = acc;
      wr_q.push_back(w);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((resp_q.size() != 0 || wr_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("resp_queue_drained", 32'(resp_q.size()), 32'd0);
    check("wr_queue_drained", 32'(wr_q.size()), 32'd0);
  endtask

  initial begin
    int acc;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    mem[0] = 32'h0102_0304;
    mem[4] = 32'h8899_AABB;
    mem[8] = 32'h5555_5555;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    #2;
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", {31'b0, resp_err}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // wr sz uns addr wdata | exp_rdata err lat | we wdata we_lat
    issue(0, 2'b00, 0, 32'h13, 0,            32'hFFFF_FF88, 0, 2, 0, 0, 0);
    issue(0, 2'b00, 1, 32'h13, 0,            32'h0000_0088, 0, 2, 0, 0, 0);
    issue(0, 2'b01, 0, 32'h10, 0,            32'hFFFF_AABB, 0, 2, 0, 0, 0);
    issue(0, 2'b10, 1, 32'h10, 0,            32'h8899_AABB, 0, 2, 0, 0, 0);
    issue(1, 2'b01, 0, 32'h12, 32'h0000_1234, 32'h0,        0, 3, 1, 32'h1234_AABB, 2);
    issue(1, 2'b00, 0, 32'h11, 32'hFFFF_FF5A, 32'h0,        0, 3, 1, 32'h1234_5ABB, 2);
    issue(0, 2'b10, 0, 32'h10, 0,            32'h1234_5ABB, 0, 2, 0, 0, 0);
    issue(1, 2'b10, 0, 32'h08, 32'hDEAD_BEEF, 32'h0,        0, 2, 1, 32'hDEAD_BEEF, 1);
    issue(0, 2'b00, 1, 32'h09, 0,            32'h0000_00BE, 0, 2, 0, 0, 0);
    issue(0, 2'b00, 0, 32'h0A, 0,            32'hFFFF_FFAD, 0, 2, 0, 0, 0);
    issue(0, 2'b01, 0, 32'h11, 0,            32'h0,         1, 1, 0, 0, 0);
    issue(0, 2'b11, 0, 32'h10, 0,            32'h0,         1, 1, 0, 0, 0);
    issue(1, 2'b10, 0, 32'h0A, 32'h1111_1111, 32'h0,        1, 1, 0, 0, 0);
`ifdef LSU_RANGE_CHECK_EN
    issue(0, 2'b10, 0, 32'h200, 0,           32'h0,         1, 1, 0, 0, 0);
`else
    issue(0, 2'b10, 0, 32'h200, 0,           32'h0102_0304, 0, 2, 0, 0, 0);
`endif
    drain();

    // Reset while a byte store sits in its read cycle: no write, no response.
    drive(1, 2'b00, 0, 32'h20, 32'h0000_0077, acc);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_mem_we", {31'b0, mem_we}, 32'd0);
    check("midrst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("midrst_req_ready", {31'b0, req_ready}, 32'd1);
    check("midrst_mem_addr", mem_addr, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_req_ready", {31'b0, req_ready}, 32'd1);

    check("mem_word4", mem[4], 32'h1234_5ABB);
    check("mem_word2", mem[2], 32'hDEAD_BEEF);
    check("mem_word8", mem[8], 32'h5555_5555);
    check("mem_word0", mem[0], 32'h0102_0304);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
